// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: show-ahead FIFO of {PC, dest reg, data} for committed register writes.
// Optional build macro TRACE_SKIP_ZERO_EN: writes to $zero are never captured.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNTW  = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Capture_En,
    input  logic            WB_RegWrite,
    input  logic [4:0]      WB_WriteReg,
    input  logic [31:0]     WB_WriteData,
    input  logic [31:0]     WB_PC,
    output logic            Rd_Valid,
    output logic [31:0]     Rd_PC,
    output logic [4:0]      Rd_Reg,
    output logic [31:0]     Rd_Data,
    input  logic            Rd_Ack,
    output logic [AW:0]     Count,
    output logic            Full,
    output logic            Overflow,
    output logic [CNTW-1:0] Drop_Count
);

    localparam int EW = 69;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            overflow_q;
    logic [CNTW-1:0] drop_q;

    logic empty;
    logic full;
    logic skip;
    logic push_req;
    logic pop;
    logic push;
    logic drop;

`ifdef TRACE_SKIP_ZERO_EN
    assign skip = (WB_WriteReg == 5'd0);
`else
    assign skip = 1'b0;
`endif

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign push_req = Capture_En & WB_RegWrite & ~skip;
    assign pop      = ~empty & Rd_Ack;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
            if (drop && (drop_q != '1)) drop_q <= drop_q + CNTW'(1);
        end
    end

    // Storage needs no reset; empty gating keeps stale contents off the outputs.
    always_ff @(posedge Clk) begin
        if (push && !Rst) mem[wr_ptr] <= {WB_PC, WB_WriteReg, WB_WriteData};
    end

    always_comb begin
        head     = mem[rd_ptr];
        Rd_Valid = ~empty;
        Rd_PC    = '0;
        Rd_Reg   = '0;
        Rd_Data  = '0;
        if (!empty) begin
            Rd_PC   = head[68:37];
            Rd_Reg  = head[36:32];
            Rd_Data = head[31:0];
        end
    end

    assign Count      = count_q;
    assign Full       = full;
    assign Overflow   = overflow_q;
    assign Drop_Count = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Capture_En = 1'b0;
    logic        WB_RegWrite = 1'b0;
    logic [4:0]  WB_WriteReg = '0;
    logic [31:0] WB_WriteData = '0;
    logic [31:0] WB_PC = '0;
    logic        Rd_Valid;
    logic [31:0] Rd_PC;
    logic [4:0]  Rd_Reg;
    logic [31:0] Rd_Data;
    logic        Rd_Ack = 1'b0;
    logic [4:0]  Count;
    logic        Full;
    logic        Overflow;
    logic [7:0]  Drop_Count;

    wb_trace_buffer #(.DEPTH(16), .AW(4), .CNTW(8)) dut (
        .Clk(Clk), .Rst(Rst), .Capture_En(Capture_En), .WB_RegWrite(WB_RegWrite),
        .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData), .WB_PC(WB_PC),
        .Rd_Valid(Rd_Valid), .Rd_PC(Rd_PC), .Rd_Reg(Rd_Reg), .Rd_Data(Rd_Data),
        .Rd_Ack(Rd_Ack), .Count(Count), .Full(Full), .Overflow(Overflow),
        .Drop_Count(Drop_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_ovf = 1'b0;
    int   m_drops = 0;
    bit   check_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pop first, then the push lands if a slot is free.
    always @(posedge Clk) begin
        bit want;
        if (Rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            want = Capture_En && WB_RegWrite;
`ifdef TRACE_SKIP_ZERO_EN
            if (WB_WriteReg == 5'd0) want = 1'b0;
`endif
            if (Rd_Ack && q.size() > 0) void'(q.pop_front());
            if (want) begin
                if (q.size() < DEPTH) q.push_back('{WB_PC, WB_WriteReg, WB_WriteData});
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            ent_t h;
            h = (q.size() > 0) ? q[0] : '0;
            chk("rd_valid", 32'(Rd_Valid), 32'(q.size() > 0));
            chk("rd_pc", Rd_PC, h.pc);
            chk("rd_reg", 32'(Rd_Reg), 32'(h.rg));
            chk("rd_data", Rd_Data, h.d);
            chk("count", 32'(Count), 32'(q.size()));
            chk("full", 32'(Full), 32'(q.size() == DEPTH));
            chk("overflow", 32'(Overflow), 32'(m_ovf));
            chk("drop_count", 32'(Drop_Count), 32'(m_drops));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] pc, input logic [4:0] rg, input logic [31:0] d,
                       input logic ack);
        Capture_En = 1'b1; WB_RegWrite = 1'b1;
        WB_PC = pc; WB_WriteReg = rg; WB_WriteData = d; Rd_Ack = ack;
        step();
        WB_RegWrite = 1'b0; Rd_Ack = 1'b0;
    endtask

    task automatic ack1();
        Rd_Ack = 1'b1;
        step();
        Rd_Ack = 1'b0;
    endtask

    initial begin
        int idx;
        int rd_idx;
        bit c;
        bit a;

        // reset state
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check_en = 1'b1;
        step();
        chk("reset_valid", 32'(Rd_Valid), 32'd0);
        chk("reset_count", 32'(Count), 32'd0);
        chk("reset_full", 32'(Full), 32'd0);
        chk("reset_ovf", 32'(Overflow), 32'd0);
        chk("reset_drops", 32'(Drop_Count), 32'd0);

        // single capture and pop
        cap(32'h0000_0010, 5'd8, 32'hDEAD_BEEF, 1'b0);
        chk("single_valid", 32'(Rd_Valid), 32'd1);
        chk("single_pc", Rd_PC, 32'h0000_0010);
        chk("single_reg", 32'(Rd_Reg), 32'd8);
        chk("single_data", Rd_Data, 32'hDEAD_BEEF);
        chk("single_count", 32'(Count), 32'd1);
        ack1();
        chk("single_pop_count", 32'(Count), 32'd0);
        chk("single_pop_valid", 32'(Rd_Valid), 32'd0);

        // overfill by three, then drain in order
        for (int i = 0; i < DEPTH + 3; i++) cap(32'(i * 4), 5'((i % 31) + 1), 32'(i), 1'b0);
        chk("ovf_full", 32'(Full), 32'd1);
        chk("ovf_count", 32'(Count), 32'd16);
        chk("ovf_flag", 32'(Overflow), 32'd1);
        chk("ovf_drops", 32'(Drop_Count), 32'd3);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_drain_data", Rd_Data, 32'(i));
            ack1();
        end
        chk("ovf_drained", 32'(Count), 32'd0);

        // push and pop on the same edge while full
        for (int i = 0; i < DEPTH; i++) cap(32'h100 + 32'(i), 5'd3, 32'(100 + i), 1'b0);
        cap(32'h200, 5'd9, 32'd999, 1'b1);
        chk("fullpp_count", 32'(Count), 32'd16);
        chk("fullpp_drops", 32'(Drop_Count), 32'd3);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fullpp_drain", Rd_Data, (i < DEPTH - 1) ? 32'(101 + i) : 32'd999);
            ack1();
        end

        // wrap: 40 captures interleaved with acks, occupancy kept <= 5
        idx = 0;
        rd_idx = 0;
        for (int cyc = 0; cyc < 600 && rd_idx < 40; cyc++) begin
            c = (idx < 40) && (q.size() < 5) && ($urandom_range(0, 2) != 0);
            a = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            if (a) begin
                chk("wrap_data", Rd_Data, 32'(rd_idx));
                rd_idx++;
            end
            Capture_En = 1'b1; WB_RegWrite = c; Rd_Ack = a;
            WB_PC = 32'(idx) << 2; WB_WriteReg = 5'((idx % 31) + 1); WB_WriteData = 32'(idx);
            if (c) idx++;
            step();
        end
        WB_RegWrite = 1'b0; Rd_Ack = 1'b0;
        chk("wrap_empty", 32'(Count), 32'd0);

        // $zero destination
        cap(32'h40, 5'd0, 32'h55, 1'b0);
`ifdef TRACE_SKIP_ZERO_EN
        chk("zero_count", 32'(Count), 32'd0);
`else
        chk("zero_count", 32'(Count), 32'd1);
        chk("zero_reg", 32'(Rd_Reg), 32'd0);
        chk("zero_data", Rd_Data, 32'h55);
`endif
        ack1();

        // reset mid-stream
        for (int i = 0; i < 7; i++) cap(32'(i), 5'd4, 32'(i), 1'b0);
        chk("pre_rst_count", 32'(Count), 32'd7);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("mid_rst_count", 32'(Count), 32'd0);
        chk("mid_rst_valid", 32'(Rd_Valid), 32'd0);
        chk("mid_rst_drops", 32'(Drop_Count), 32'd0);

        // Drop_Count saturation
        for (int i = 0; i < 280; i++) cap(32'(i), 5'd7, 32'(i), 1'b0);
        chk("sat_drops", 32'(Drop_Count), 32'd255);
        chk("sat_count", 32'(Count), 32'd16);
        chk("sat_ovf", 32'(Overflow), 32'd1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            Rst          = ($urandom_range(0, 199) == 0);
            Capture_En   = ($urandom_range(0, 3) != 0);
            WB_RegWrite  = ($urandom_range(0, 2) != 0);
            WB_WriteReg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            WB_WriteData = $urandom;
            WB_PC        = $urandom;
            Rd_Ack       = ($urandom_range(0, 2) == 0);
            step();
        end
        Rst = 1'b0; WB_RegWrite = 1'b0; Rd_Ack = 1'b0;
        step();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
